// File: rtl/packet_sink_node_if.sv
// rtl/packet_sink_node_if.sv - flit link and PE packet delivery signals of the sink node
interface packet_sink_node_if #(
  parameter int FLIT_W = 32
);
  logic [FLIT_W-1:0]   flit_din;
  logic                flit_valid_din;
  logic                credit_dout;
  logic [5*FLIT_W-1:0] packet_dout;
  logic                packet_valid_dout;
  logic                packet_ack_din;
  logic                dest_error_dout;
  logic [31:0]         packet_count_dout;
  logic [31:0]         drop_count_dout;
  logic                overflow_dout;

  modport slave (
    input  flit_din, flit_valid_din, packet_ack_din,
    output credit_dout, packet_dout, packet_valid_dout, dest_error_dout,
           packet_count_dout, drop_count_dout, overflow_dout
  );

  modport master (
    output flit_din, flit_valid_din, packet_ack_din,
    input  credit_dout, packet_dout, packet_valid_dout, dest_error_dout,
           packet_count_dout, drop_count_dout, overflow_dout
  );
endinterface

// File: rtl/packet_sink_node.sv
// rtl/packet_sink_node.sv - credit-flow flit receiver reassembling 5-flit packets for the local PE
module packet_sink_node #(
  parameter int X_LOCAL    = 2,
  parameter int Y_LOCAL    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FLIT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  packet_sink_node_if.slave     link
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] X_ID = 3'(X_LOCAL);
  localparam logic [2:0] Y_ID = 3'(Y_LOCAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_HOLD
  } state_t;

  logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [FLIT_W-1:0] head_flit;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [FLIT_W-1:0] word_q [5];
  logic [FLIT_W-1:0] word_d [5];
  logic              valid_q, valid_d;
  logic              derr_q, derr_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              credit_q;

  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = link.flit_valid_din && !fifo_full;
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_BODY));
  assign head_flit  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign overflow_d = overflow_q | (link.flit_valid_din & fifo_full);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= link.flit_din;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    valid_d    = valid_q;
    derr_d     = derr_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head_flit[31:30] == 2'b10) begin
            word_d[0] = head_flit;
            idx_d     = 3'd1;
            state_d   = S_BODY;
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end
        end
      end
      S_BODY: begin
        // Body flits are taken on count alone; their type field is not inspected.
        if (pop) begin
          word_d[idx_q] = head_flit;
          if (idx_q == 3'd4) begin
            state_d   = S_HOLD;
            valid_d   = 1'b1;
            derr_d    = (word_q[0][29:27] != X_ID) || (word_q[0][26:24] != Y_ID);
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (link.packet_ack_din) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        word_q[i] <= '0;
      end
      valid_q    <= 1'b0;
      derr_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      credit_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      derr_q     <= derr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      credit_q   <= pop;
    end
  end

  assign link.credit_dout       = credit_q;
  assign link.packet_dout       = {word_q[4], word_q[3], word_q[2], word_q[1], word_q[0]};
  assign link.packet_valid_dout = valid_q;
  assign link.dest_error_dout   = derr_q;
  assign link.packet_count_dout = pkt_cnt_q;
  assign link.drop_count_dout   = drop_cnt_q;
  assign link.overflow_dout     = overflow_q;

endmodule

// File: tb/tb_packet_sink_node.sv
// tb/tb_packet_sink_node.sv - directed and random bench for packet_sink_node
module tb_packet_sink_node;
  localparam int DEPTH = 8;
  localparam int TXN   = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  packet_sink_node_if #(.FLIT_W(32)) bus ();

  packet_sink_node #(
    .X_LOCAL(2), .Y_LOCAL(2), .FIFO_DEPTH(DEPTH), .FLIT_W(32)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .link  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]  tx_mem [TXN];
  int           tx_wr = 0;
  int           tx_rd = 0;
  int           credits_avail = DEPTH;
  int           credit_cnt = 0;
  int           vcyc = 0;
  int           ack_mode = 0;
  bit           force_tx = 1'b0;
  logic [159:0] rx_q [$];
  logic         rx_err_q [$];

  logic [159:0] exp_pk [1000];
  logic         exp_er [1000];

  // Sender, PE and credit monitor; all activity happens on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      credits_avail       = DEPTH;
      tx_rd               = tx_wr;
      bus.flit_valid_din  = 1'b0;
      bus.flit_din        = '0;
      bus.packet_ack_din  = 1'b0;
    end else begin
      if (bus.credit_dout) begin
        credits_avail++;
        credit_cnt++;
      end
      if (bus.packet_valid_dout) vcyc++;
      case (ack_mode)
        0:       bus.packet_ack_din = 1'b1;
        1:       bus.packet_ack_din = ($urandom_range(0, 3) == 0);
        default: bus.packet_ack_din = 1'b0;
      endcase
      if (bus.packet_valid_dout && bus.packet_ack_din) begin
        rx_q.push_back(bus.packet_dout);
        rx_err_q.push_back(bus.dest_error_dout);
      end
      if ((tx_wr != tx_rd) && (credits_avail > 0 || force_tx)) begin
        bus.flit_din       = tx_mem[tx_rd % TXN];
        bus.flit_valid_din = 1'b1;
        tx_rd++;
        if (credits_avail > 0) credits_avail--;
      end else begin
        bus.flit_valid_din = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] f);
    tx_mem[tx_wr % TXN] = f;
    tx_wr++;
  endtask

  task automatic put_pkt(input logic [159:0] p);
    for (int i = 0; i < 5; i++) put(p[i*32 +: 32]);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_tx_empty();
    int c = 0;
    while (tx_wr != tx_rd && c < 2000) begin
      tick();
      c++;
    end
  endtask

  logic [159:0] p1, p2, p3, pa, pb, pc, p6, pk;
  logic [31:0]  hdr;
  int c0, v0, n0, base, nbad, lim;

  initial begin
    p1 = {"DAT4", "DAT3", "DAT2", "DAT1", 32'h9259_2D2D};
    p2 = {"BBB4", "BBB3", "BBB2", "BBB1", 32'h9C00_0001};
    p3 = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h9200_0003};
    pa = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'h9200_00AA};
    pb = {32'hB000_0004, 32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'h9200_00BB};
    pc = {32'hC000_0004, 32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'h9200_00CC};
    p6 = {32'h6000_0004, 32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h9212_3456};

    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", bus.packet_valid_dout, 0);
    check("rst_credit", bus.credit_dout, 0);
    check("rst_packet", bus.packet_dout, 0);
    check("rst_pcount", bus.packet_count_dout, 0);
    check("rst_overflow", bus.overflow_dout, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single packet, ack held high.
    c0 = credit_cnt;
    v0 = vcyc;
    put_pkt(p1);
    wait_rx(1, 200, "t1_rx");
    repeat (3) tick();
    check("t1_credits", credit_cnt - c0, 5);
    check("t1_packet", rx_q[0], p1);
    check("t1_dest_err", rx_err_q[0], 0);
    check("t1_valid_cycles", vcyc - v0, 1);
    check("t1_pcount", bus.packet_count_dout, 1);

    // Destination (3,4) is not this node.
    put_pkt(p2);
    wait_rx(2, 200, "t2_rx");
    tick();
    check("t2_packet", rx_q[1], p2);
    check("t2_dest_err", rx_err_q[1], 1);
    check("t2_pcount", bus.packet_count_dout, 2);

    // Non-header flit in IDLE is dropped but still credited.
    c0 = credit_cnt;
    put(32'h0000_0000);
    put_pkt(p3);
    wait_rx(3, 200, "t3_rx");
    repeat (3) tick();
    check("t3_drop", bus.drop_count_dout, 1);
    check("t3_credits", credit_cnt - c0, 6);
    check("t3_packet", rx_q[2], p3);
    check("t3_pcount", bus.packet_count_dout, 3);

    // PE stalls: FIFO fills, ninth flit overflows, queued flits survive.
    ack_mode = 2;
    put_pkt(pa);
    lim = 0;
    while (!bus.packet_valid_dout && lim < 200) begin
      tick();
      lim++;
    end
    check("t4_hold_valid", bus.packet_valid_dout, 1);
    c0 = credit_cnt;
    put_pkt(pb);
    put(pc[31:0]);
    put(pc[63:32]);
    put(pc[95:64]);
    wait_tx_empty();
    repeat (2) tick();
    check("t4_no_overflow_8", bus.overflow_dout, 0);
    force_tx = 1'b1;
    put(32'hDEAD_BEEF);
    wait_tx_empty();
    repeat (2) tick();
    force_tx = 1'b0;
    check("t4_overflow", bus.overflow_dout, 1);
    check("t4_hold_credits", credit_cnt - c0, 0);
    check("t4_hold_packet", bus.packet_dout, pa);
    ack_mode = 0;
    put(pc[127:96]);
    put(pc[159:128]);
    wait_rx(6, 400, "t4_rx");
    check("t4_pkt_a", rx_q[3], pa);
    check("t4_pkt_b", rx_q[4], pb);
    check("t4_pkt_c", rx_q[5], pc);
    check("t4_pcount", bus.packet_count_dout, 6);

    // Asynchronous reset after three flits of a packet.
    base = tx_wr;
    put_pkt(pb);
    lim = 0;
    while ((tx_rd - base) < 3 && lim < 200) begin
      tick();
      lim++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", bus.packet_valid_dout, 0);
    check("t6_packet", bus.packet_dout, 0);
    check("t6_pcount", bus.packet_count_dout, 0);
    check("t6_drop", bus.drop_count_dout, 0);
    check("t6_overflow", bus.overflow_dout, 0);
    check("t6_credit", bus.credit_dout, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    put_pkt(p6);
    wait_rx(7, 200, "t6_rx");
    tick();
    check("t6_fresh_packet", rx_q[6], p6);
    check("t6_fresh_pcount", bus.packet_count_dout, 1);

    // 1000 random packets with random PE ack delays.
    c0 = credit_cnt;
    n0 = rx_q.size();
    ack_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      hdr = {2'b10, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 24'($urandom)};
      pk  = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), hdr};
      exp_pk[k] = pk;
      exp_er[k] = (hdr[29:27] != 3'd2) || (hdr[26:24] != 3'd2);
      put_pkt(pk);
    end
    wait_rx(n0 + 1000, 60000, "t5_rx");
    repeat (3) tick();
    nbad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (n0 + k >= rx_q.size()) nbad++;
      else if (rx_q[n0 + k] !== exp_pk[k] || rx_err_q[n0 + k] !== exp_er[k]) nbad++;
    end
    check("t5_pkt_errors", nbad, 0);
    check("t5_credits", credit_cnt - c0, 5000);
    check("t5_overflow", bus.overflow_dout, 0);
    check("t5_pcount", bus.packet_count_dout, 1001);
    check("t5_drop", bus.drop_count_dout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
